// File: rtl/subset3_pkg.sv
// rtl/subset3_pkg.sv - shared field positions, encodings and FSM states for the subset3 index table updater
package subset3_pkg;

    localparam int         GROUP_CNT = 5;
    localparam logic [2:0] GROUP_MAX = 3'd4;

    // Field positions in the 60-bit index_table word; each idx field is 11 bits wide
    localparam logic [5:0] G0_IDX_LSB = 6'd49;
    localparam logic [5:0] G0_FLAG    = 6'd48;
    localparam logic [5:0] G1_IDX_LSB = 6'd37;
    localparam logic [5:0] G1_FLAG    = 6'd36;
    localparam logic [5:0] G2_IDX_LSB = 6'd25;
    localparam logic [5:0] G2_FLAG    = 6'd24;
    localparam logic [5:0] G3_IDX_LSB = 6'd13;
    localparam logic [5:0] G3_FLAG    = 6'd12;
    localparam logic [5:0] G4_IDX_LSB = 6'd1;
    localparam logic [5:0] G4_FLAG    = 6'd0;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_DELETE = 1'b1;

    localparam logic [1:0] STATUS_OK         = 2'd0;
    localparam logic [1:0] STATUS_OVERFLOW   = 2'd1;
    localparam logic [1:0] STATUS_UNDERFLOW  = 2'd2;
    localparam logic [1:0] STATUS_BAD_GROUP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_UPDATE = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    function automatic logic [5:0] idx_lsb(input logic [2:0] g);
        case (g)
            3'd0:    return G0_IDX_LSB;
            3'd1:    return G1_IDX_LSB;
            3'd2:    return G2_IDX_LSB;
            3'd3:    return G3_IDX_LSB;
            default: return G4_IDX_LSB;
        endcase
    endfunction

    function automatic logic [5:0] flag_bit(input logic [2:0] g);
        case (g)
            3'd0:    return G0_FLAG;
            3'd1:    return G1_FLAG;
            3'd2:    return G2_FLAG;
            3'd3:    return G3_FLAG;
            default: return G4_FLAG;
        endcase
    endfunction

endpackage

// File: rtl/subset3_group_counter_bank.sv
// rtl/subset3_group_counter_bank.sv - five per-group rule counters with select and saturation flags
module subset3_group_counter_bank
    import subset3_pkg::*;
#(
    parameter int CNT_BIT_LEN = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             i_sel,
    input  logic                   i_inc,
    input  logic                   i_dec,
    output logic [CNT_BIT_LEN-1:0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    logic [CNT_BIT_LEN-1:0] r_cnt [GROUP_CNT];
    logic                   w_sel_ok;

    assign w_sel_ok = (i_sel <= GROUP_MAX);

    // Selected counter view; an out-of-range group reads as zero
    always_comb begin
        o_count = '0;
        if (w_sel_ok) begin
            o_count = r_cnt[i_sel];
        end
        o_full  = &o_count;
        o_empty = (o_count == '0);
    end

    // Counter update; saturating so a stray strobe can never wrap a count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GROUP_CNT; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_sel_ok) begin
            if (i_inc && !o_full) begin
                r_cnt[i_sel] <= o_count + CNT_BIT_LEN'(1);
            end else if (i_dec && !o_empty) begin
                r_cnt[i_sel] <= o_count - CNT_BIT_LEN'(1);
            end
        end
    end

endmodule

// File: rtl/subset3_index_table_updater.sv
// rtl/subset3_index_table_updater.sv - rule insert/delete handler that rebuilds and publishes the index_table word
module subset3_index_table_updater
    import subset3_pkg::*;
#(
    parameter int INDEX_BIT_LEN = 11,
    parameter int CNT_BIT_LEN   = 8,
    parameter int SMALL_THRESH  = 1,
    parameter int TABLE_BIT_LEN = 60
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_op,
    input  logic [2:0]               req_group,
    input  logic [INDEX_BIT_LEN-1:0] req_index,
    output logic                     tbl_wr_valid,
    input  logic                     tbl_wr_ready,
    output logic [TABLE_BIT_LEN-1:0] index_table,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_status
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_op;
    logic [2:0]               r_group;
    logic [INDEX_BIT_LEN-1:0] r_index;
    logic [1:0]               r_status;
    logic [CNT_BIT_LEN-1:0]   r_new_count;
    logic [TABLE_BIT_LEN-1:0] r_table;

    logic [CNT_BIT_LEN-1:0]   w_count;
    logic                     w_full;
    logic                     w_empty;
    logic [1:0]               w_chk_status;
    logic [5:0]               w_lsb;
    logic [5:0]               w_flag_pos;
    logic [TABLE_BIT_LEN-1:0] w_table_next;

    subset3_group_counter_bank #(
        .CNT_BIT_LEN (CNT_BIT_LEN)
    ) u_counter_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sel   (r_group),
        .i_inc   ((r_state == S_UPDATE) && (r_op == OP_INSERT)),
        .i_dec   ((r_state == S_UPDATE) && (r_op == OP_DELETE)),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Request legality against the latched group's current count
    always_comb begin
        w_chk_status = STATUS_OK;
        if (r_group > GROUP_MAX) begin
            w_chk_status = STATUS_BAD_GROUP;
        end else if ((r_op == OP_INSERT) && w_full) begin
            w_chk_status = STATUS_OVERFLOW;
        end else if ((r_op == OP_DELETE) && w_empty) begin
            w_chk_status = STATUS_UNDERFLOW;
        end
    end

    // New table word: only the target group's flag and idx field move; a big group keeps its idx
    always_comb begin
        w_table_next = r_table;
        w_lsb        = idx_lsb(r_group);
        w_flag_pos   = flag_bit(r_group);
        if (r_new_count > CNT_BIT_LEN'(SMALL_THRESH)) begin
            w_table_next[w_flag_pos] = 1'b1;
        end else begin
            w_table_next[w_flag_pos] = 1'b0;
            w_table_next[w_lsb +: INDEX_BIT_LEN] = (r_new_count == '0) ? '0 : r_index;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        tbl_wr_valid = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_next = (w_chk_status == STATUS_OK) ? S_UPDATE : S_RESP;
            end
            S_UPDATE: begin
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                tbl_wr_valid = 1'b1;
                if (tbl_wr_ready) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid    = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request latch, check result and table register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= OP_INSERT;
            r_group     <= '0;
            r_index     <= '0;
            r_status    <= STATUS_OK;
            r_new_count <= '0;
            r_table     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_group <= req_group;
                        r_index <= req_index;
                    end
                end
                S_CHECK: begin
                    r_status    <= w_chk_status;
                    r_new_count <= (r_op == OP_DELETE) ? (w_count - CNT_BIT_LEN'(1))
                                                       : (w_count + CNT_BIT_LEN'(1));
                end
                S_UPDATE: begin
                    r_table <= w_table_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign index_table = r_table;
    assign rsp_status  = r_status;

endmodule
